vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Downstream consumer of the VGA timing generator (vgaHandler).
- Takes the registered pixel/line counters, the hSync/vSync and the composite blank, and issues read addresses to an external synchronous framebuffer RAM.
- Converts the returned RGB332 byte into pixel colour.
- Delays sync so colour and sync reach the DAC pins aligned.
- Owns a double-buffer select with a frame-boundary swap handshake.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SCALE_SHIFT, 2, log2 of pixel replication (framebuffer is H_ACTIVE>>2 x V_ACTIVE>>2)
FB_WIDTH, 160, framebuffer words per row (= H_ACTIVE>>SCALE_SHIFT)
ADDR_W, 15, word address width within one buffer
H_POL, 0, hSync active level (idle = ~H_POL)
V_POL, 0, vSync active level (idle = ~V_POL)

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
hSyncIn  in  1  horizontal sync from timing generator
vSyncIn  in  1  vertical sync from timing generator
pixelCnt  in  10  current pixel in line
lineCnt  in  9  current line in frame
compBlank  in  1  composite blank, high outside the display region
swapReq  in  1  single-cycle pulse requesting a buffer swap
swapAck  out  1  single-cycle pulse: swap performed
displayBuf  out  1  buffer currently scanned out
memAddr  out  ADDR_W+1  {displayBuf, word address}, registered
memData  in  8  RAM read data, RGB332, valid the cycle after memAddr is sampled by the RAM
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
hSyncOut  out  1  hSyncIn delayed 3 clocks
vSyncOut  out  1  vSyncIn delayed 3 clocks
frameCnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async):
  - red/green/blue = 0, memAddr = 0, displayBuf = 0, swapAck = 0, frameCnt = 0.
  - rowBase = 0, swap pending = 0.
  - hSyncOut = ~H_POL, vSyncOut = ~V_POL; all internal delay stages load the same idle/blank values.
- Pipeline: inputs sampled at edge E0.
  - E1: memAddr registered; stage-1 copies of the syncs and the blank.
  - E2: RAM captures memAddr; stage-2 copies.
  - E3: colour = blank2 ? 0 : memData, giving red=memData[7:5], green=[4:2], blue=[1:0]; hSyncOut/vSyncOut updated.
  - Total latency is exactly 3 clocks for colour and sync alike. Blanked pixels are always black regardless of memData.
- Address:
  - memAddr = {displayBuf, rowBase + (pixelCnt >> SCALE_SHIFT)}, truncated to ADDR_W.
  - During blank, the address value is don't-care but must stay registered (no X).
- rowBase update, at pixelCnt == H_ACTIVE only:
  - lineCnt >= V_ACTIVE-1: rowBase <= 0. This prepares the next frame and holds rowBase at 0 through vertical blank.
  - else if (lineCnt+1) low SCALE_SHIFT bits are 0: rowBase <= rowBase + FB_WIDTH.
  - otherwise hold.
- Swap:
  - A swapReq pulse sets the pending flag. Pulses while already pending merge into the same request.
  - Frame boundary event: lineCnt == V_ACTIVE and pixelCnt == 0.
  - At the event: frameCnt increments. If pending (or swapReq is high that same cycle), displayBuf toggles, swapAck pulses high for 1 cycle, and pending clears.
  - displayBuf never changes mid-visible-frame.
- Reset mid-frame: all state returns to reset values immediately. Fetching resumes correctly from the next inputs, and addresses are valid from the next frame start.

Optional Feature:
TEST_PATTERN_EN
- Defined:
  - Adds input port testMode (1 bit).
  - When testMode is high, colour comes from 8 vertical bars instead of memData, with the same 3-clock latency and blank forcing.
  - The bar index k is a 3-bit counter cleared at pixelCnt == 0. It increments every H_ACTIVE/8 pixels, tracked by a sub-counter, so no divider is needed.
  - Bar colour: red={3{k[2]}}, green={3{k[1]}}, blue={2{k[0]}}.
  - memAddr continues to be generated.
- Undefined: no testMode port; colour always comes from memData.

Test Plan:
- Reset with timing running -> outputs black, memAddr=0, displayBuf=0, hSyncOut=1/vSyncOut=1 for H_POL=V_POL=0; release -> first valid colour appears 3 clocks after pixel (0,0) is presented.
- Pixel (0,0) then (4,4), with memData model = addr[7:0] -> memAddr=0 then 161; colour at E3 = 0x00 then 0xA1 (red=5, green=0, blue=1).
- Pixel (639,479) -> memAddr=19199; pixel (640,479) -> rowBase returns to 0 and line 0 of the next frame addresses from 0.
- compBlank=1 with memData=0xFF -> red/green/blue=0 three clocks later; hSyncIn toggle -> hSyncOut toggles exactly 3 clocks later.
- swapReq pulse at line 100 plus a second pulse at line 200 -> no change until (480,0), then displayBuf=1, one swapAck pulse, frameCnt+1; the next frame's memAddr MSB=1; the following boundary gives no swap.
- TEST_PATTERN_EN, testMode=1, H_ACTIVE=640 -> pixels 0..79 black, 80..159 blue=3 only, 560..639 white (7,7,3).

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch stage behind the VGA timing generator: issues RAM reads, returns
// colour and sync aligned 3 clocks later, and double-buffers on frame boundaries.
// Optional TEST_PATTERN_EN adds a testMode input that replaces RAM data with 8 colour bars.
module vga_pixel_fetch #(
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   SCALE_SHIFT = 2,
  parameter int   FB_WIDTH    = 160,
  parameter int   ADDR_W      = 15,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hSyncIn,
  input  logic              vSyncIn,
  input  logic [9:0]        pixelCnt,
  input  logic [8:0]        lineCnt,
  input  logic              compBlank,
`ifdef TEST_PATTERN_EN
  input  logic              testMode,
`endif
  input  logic              swapReq,
  output logic              swapAck,
  output logic              displayBuf,
  output logic [ADDR_W:0]   memAddr,
  input  logic [7:0]        memData,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic [7:0]        frameCnt
);

  logic [ADDR_W-1:0] rowBase;
  logic              swapPending;
  logic              hSync1, hSync2, vSync1, vSync2;
  logic              blank1, blank2;
  logic [7:0]        colour, colourNext;
  logic              frameEvent;

  assign frameEvent = (lineCnt == 9'(V_ACTIVE)) && (pixelCnt == 10'd0);

  // Address fetch and row base tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memAddr <= '0;
      rowBase <= '0;
    end else begin
      memAddr <= {displayBuf, rowBase + ADDR_W'(pixelCnt >> SCALE_SHIFT)};
      if (pixelCnt == 10'(H_ACTIVE)) begin
        if (lineCnt >= 9'(V_ACTIVE - 1)) begin
          rowBase <= '0;
        end else if (lineCnt[SCALE_SHIFT-1:0] == '1) begin
          // Next line starts a new framebuffer row.
          rowBase <= rowBase + ADDR_W'(FB_WIDTH);
        end
      end
    end
  end

  // Sync and blank delay lines; the RAM supplies the middle stage for data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hSync1   <= ~H_POL;
      hSync2   <= ~H_POL;
      hSyncOut <= ~H_POL;
      vSync1   <= ~V_POL;
      vSync2   <= ~V_POL;
      vSyncOut <= ~V_POL;
      blank1   <= 1'b1;
      blank2   <= 1'b1;
      colour   <= '0;
    end else begin
      hSync1   <= hSyncIn;
      hSync2   <= hSync1;
      hSyncOut <= hSync2;
      vSync1   <= vSyncIn;
      vSync2   <= vSync1;
      vSyncOut <= vSync2;
      blank1   <= compBlank;
      blank2   <= blank1;
      colour   <= colourNext;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_WIDTH = H_ACTIVE / 8;

  logic [2:0] barIdx, barIdxCur, bar1, bar2;
  logic [9:0] barSub, barSubCur;
  logic       test1, test2;

  always_comb begin
    barIdxCur = (pixelCnt == 10'd0) ? 3'd0 : barIdx;
    barSubCur = (pixelCnt == 10'd0) ? 10'd0 : barSub;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      barIdx <= '0;
      barSub <= '0;
      bar1   <= '0;
      bar2   <= '0;
      test1  <= 1'b0;
      test2  <= 1'b0;
    end else begin
      if (barSubCur == 10'(BAR_WIDTH - 1)) begin
        barSub <= '0;
        barIdx <= 3'(barIdxCur + 3'd1);
      end else begin
        barSub <= barSubCur + 10'd1;
        barIdx <= barIdxCur;
      end
      bar1  <= barIdxCur;
      bar2  <= bar1;
      test1 <= testMode;
      test2 <= test1;
    end
  end

  always_comb begin
    colourNext = memData;
    if (blank2) begin
      colourNext = '0;
    end else if (test2) begin
      colourNext = {{3{bar2[2]}}, {3{bar2[1]}}, {2{bar2[0]}}};
    end
  end
`else
  always_comb begin
    colourNext = blank2 ? 8'h00 : memData;
  end
`endif

  assign red   = colour[7:5];
  assign green = colour[4:2];
  assign blue  = colour[1:0];

  // Buffer swap only at the frame boundary, so the visible frame never tears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      displayBuf  <= 1'b0;
      swapPending <= 1'b0;
      swapAck     <= 1'b0;
      frameCnt    <= '0;
    end else begin
      swapAck <= 1'b0;
      if (frameEvent) begin
        frameCnt <= frameCnt + 8'd1;
        if (swapPending || swapReq) begin
          displayBuf  <= ~displayBuf;
          swapAck     <= 1'b1;
          swapPending <= 1'b0;
        end
      end else if (swapReq) begin
        swapPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: randomized scan with a closed-form address model.
module tb_vga_pixel_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hSyncIn = 1'b1, vSyncIn = 1'b1;
  logic [9:0]  pixelCnt = '0;
  logic [8:0]  lineCnt = '0;
  logic        compBlank = 1'b1;
  logic        swapReq = 1'b0;
  logic        swapAck, displayBuf;
  logic [15:0] memAddr;
  logic [7:0]  memData = '0;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        hSyncOut, vSyncOut;
  logic [7:0]  frameCnt;
`ifdef TEST_PATTERN_EN
  logic        testMode = 1'b0;
`endif

  vga_pixel_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .hSyncIn    (hSyncIn),
    .vSyncIn    (vSyncIn),
    .pixelCnt   (pixelCnt),
    .lineCnt    (lineCnt),
    .compBlank  (compBlank),
`ifdef TEST_PATTERN_EN
    .testMode   (testMode),
`endif
    .swapReq    (swapReq),
    .swapAck    (swapAck),
    .displayBuf (displayBuf),
    .memAddr    (memAddr),
    .memData    (memData),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hSyncOut   (hSyncOut),
    .vSyncOut   (vSyncOut),
    .frameCnt   (frameCnt)
  );

  always #5 clock = ~clock;

  // Synchronous RAM whose contents are the low address byte.
  logic memForce = 1'b0;
  always @(posedge clock) memData <= memForce ? 8'hFF : memAddr[7:0];

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  col;
    logic        hs;
    logic        vs;
    logic        addrChk;
    logic        colChk;
  } entry_t;

  localparam entry_t IdleEntry = '{addr: 16'h0, col: 8'h0, hs: 1'b1, vs: 1'b1,
                                   addrChk: 1'b0, colChk: 1'b1};

  entry_t     hist [3];
  int         total = 0;
  int         bad = 0;
  logic       dispModel = 1'b0;
  logic       pendModel = 1'b0;
  logic [7:0] frameModel = '0;
  logic       addrValid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    chk("rst_colour", {24'h0, red, green, blue}, 32'h0);
    chk("rst_memAddr", {16'h0, memAddr}, 32'h0);
    chk("rst_displayBuf", {31'h0, displayBuf}, 32'h0);
    chk("rst_swapAck", {31'h0, swapAck}, 32'h0);
    chk("rst_frameCnt", {24'h0, frameCnt}, 32'h0);
    chk("rst_hSyncOut", {31'h0, hSyncOut}, 32'h1);
    chk("rst_vSyncOut", {31'h0, vSyncOut}, 32'h1);
    for (int i = 0; i < 3; i++) hist[i] = IdleEntry;
    dispModel = 1'b0;
    pendModel = 1'b0;
    frameModel = '0;
    addrValid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input int pix, input int line, input bit blank, input bit req);
    entry_t e;
    logic   expAck;
    pixelCnt = 10'(pix);
    lineCnt = 9'(line);
    compBlank = blank;
    swapReq = req;
    hSyncIn = 1'($urandom);
    vSyncIn = 1'($urandom);
    if (line == 0 && pix == 0) addrValid = 1'b1;
    // Framebuffer is 160x120, each word replicated over a 4x4 pixel block.
    e.addr = {dispModel, 15'((line / 4) * 160 + pix / 4)};
    e.addrChk = addrValid && !blank;
    e.col = blank ? 8'h00 : e.addr[7:0];
    e.colChk = blank || addrValid;
`ifdef TEST_PATTERN_EN
    if (testMode && !blank) begin
      logic [2:0] k;
      k = 3'(pix / 80);
      e.col = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
      e.colChk = 1'b1;
    end
`endif
    e.hs = hSyncIn;
    e.vs = vSyncIn;
    expAck = 1'b0;
    if (line == 480 && pix == 0) begin
      frameModel = frameModel + 8'd1;
      if (pendModel || req) begin
        dispModel = ~dispModel;
        expAck = 1'b1;
        pendModel = 1'b0;
      end
    end else if (req) begin
      pendModel = 1'b1;
    end
    @(posedge clock);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = e;
    if (hist[0].addrChk) chk("memAddr", {16'h0, memAddr}, {16'h0, hist[0].addr});
    chk("displayBuf", {31'h0, displayBuf}, {31'h0, dispModel});
    chk("swapAck", {31'h0, swapAck}, {31'h0, expAck});
    chk("frameCnt", {24'h0, frameCnt}, {24'h0, frameModel});
    if (hist[2].colChk) chk("colour", {24'h0, red, green, blue}, {24'h0, hist[2].col});
    chk("hSyncOut", {31'h0, hSyncOut}, {31'h0, hist[2].hs});
    chk("vSyncOut", {31'h0, vSyncOut}, {31'h0, hist[2].vs});
  endtask

  task automatic scanFrame(input int lastLine, input int req1, input int req2, input bit reqEvt);
    for (int line = 0; line <= lastLine; line++) begin
      step(0, line, 1'b0, 1'b0);
      step(4, line, 1'b0, 1'b0);
      if (line == 4) chk("addr_4_4", {17'h0, memAddr[14:0]}, 32'd161);
      step(int'($urandom_range(638, 1)), line, 1'b0, 1'b0);
      step(639, line, 1'b0, 1'b0);
      if (line == 479) chk("addr_639_479", {17'h0, memAddr[14:0]}, 32'd19199);
      step(640, line, 1'b1, (line == req1) || (line == req2));
      step(int'($urandom_range(799, 641)), line, 1'b1, 1'b0);
    end
    if (lastLine == 479) begin
      step(0, 480, 1'b1, reqEvt);
      step(100, 490, 1'b1, 1'b0);
      step(700, 500, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    doReset();
    // Two merged swap requests take effect at the first boundary only.
    scanFrame(479, 100, 200, 1'b0);
    scanFrame(479, -1, -1, 1'b0);
    // Blanked pixels stay black even when the RAM returns all ones.
    memForce = 1'b1;
    for (int i = 0; i < 6; i++) step(300, 300, 1'b1, 1'b0);
    memForce = 1'b0;
    for (int i = 0; i < 3; i++) step(300, 300, 1'b1, 1'b0);
    // Request coinciding with the boundary swaps immediately.
    scanFrame(479, -1, -1, 1'b1);
`ifdef TEST_PATTERN_EN
    testMode = 1'b1;
    for (int p = 0; p < 640; p++) step(p, 0, 1'b0, 1'b0);
    step(640, 0, 1'b1, 1'b0);
    testMode = 1'b0;
    for (int i = 0; i < 3; i++) step(700, 0, 1'b1, 1'b0);
`endif
    // Reset mid-frame, then a clean frame with a swap request.
    scanFrame(50, 20, -1, 1'b0);
    step(123, 51, 1'b0, 1'b0);
    doReset();
    scanFrame(479, 300, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
